// File: rtl/vigna_bus_pkg.sv
// Shared definitions for the vigna bus arbiter: state encoding, default error data
// and an elaboration-time clog2 helper.
package vigna_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/vigna_rr_pick.sv
// Round-robin winner selection: first requester scanning upward from last+1, wrapping.
module vigna_rr_pick
  import vigna_bus_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx
);

  logic             lo_found;
  logic             hi_found;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;

  // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(j);
      end
      if (req[j] && (j > int'(last))) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(j);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    win_oh  = lo_found ? (N'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/vigna_bus_arbiter.sv
// N-master round-robin arbiter for the vigna valid/ready memory port, with a
// programmable hung-transaction timeout that completes with an error.
module vigna_bus_arbiter
  import vigna_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 256,
  parameter logic [31:0] ERR_RDATA   = DEFAULT_ERR_RDATA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_MASTERS-1:0]   m_valid,
  output logic [NUM_MASTERS-1:0]   m_ready,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  input  logic [4*NUM_MASTERS-1:0] m_wstrb,
  output logic [31:0]              m_rdata,
  output logic                     s_valid,
  input  logic                     s_ready,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [31:0]              s_rdata,
  output logic [NUM_MASTERS-1:0]   grant,
  output logic                     bus_err
);

  localparam int unsigned IDX_W = clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  state_e                 state_q, state_d;
  logic [31:0]            s_addr_q, s_addr_d;
  logic [31:0]            s_wdata_q, s_wdata_d;
  logic [3:0]             s_wstrb_q, s_wstrb_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [31:0]            addr_a  [NUM_MASTERS];
  logic [31:0]            wdata_a [NUM_MASTERS];
  logic [3:0]             wstrb_a [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   busy;
  logic                   done_ok;
  logic                   tmo_hit;

  always_comb begin
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      addr_a[i]  = m_addr[32*i +: 32];
      wdata_a[i] = m_wdata[32*i +: 32];
      wstrb_a[i] = m_wstrb[4*i +: 4];
    end
  end

  vigna_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (m_valid),
    .last    (last_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  // Normal completion takes precedence over a coinciding timeout; reset masks both.
  assign busy    = (state_q == BUSY);
  assign done_ok = !reset && busy && s_ready;
  assign tmo_hit = !reset && busy && !s_ready && (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (|m_valid) begin
          state_d   = BUSY;
          s_addr_d  = addr_a[pick_idx];
          s_wdata_d = wdata_a[pick_idx];
          s_wstrb_d = wstrb_a[pick_idx];
          grant_d   = pick_oh;
          gidx_d    = pick_idx;
          cnt_d     = '0;
        end
      end
      BUSY: begin
        if (done_ok || tmo_hit) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end else if ((TIMEOUT != 0) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_valid = busy;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wstrb = s_wstrb_q;
  assign grant   = grant_q;
  assign m_ready = (done_ok || tmo_hit) ? grant_q : '0;
  assign m_rdata = tmo_hit ? ERR_RDATA : s_rdata;
  assign bus_err = tmo_hit;

endmodule
